serial_fetch_arbiter: RTL
=========================

Name: serial_fetch_arbiter

Overview:
- Shares one serial external-memory port between the instruction-fetch requester (I) and the micro-instruction-fetch requester (M) of the micro-coded CPU.
- Arbitrates round-robin and latches the winner's address.
- Shifts the address out MSB-first, waits a fixed turnaround, then shifts the fetched word in MSB-first.
- Returns the word in parallel with a one-cycle done pulse, so the CPU FSM no longer counts serial bits itself.

Parameters:
- IADDR_W, 8, instruction address width (PC width)
- MADDR_W, 9, micro-instruction address width
- IDATA_W, 16, instruction word width
- MDATA_W, 16, micro-instruction word width
- TURNAROUND, 1, idle cycles between last address bit and first data bit (0..3)

Ports:
- sys_clk  in  1  system clock; all state changes on its rising edge
- sys_reset  in  1  asynchronous, active-low reset (asserted at 0)
- i_req  in  1  instruction fetch request; held until i_done
- i_addr  in  IADDR_W  instruction address; sampled at grant
- i_gnt  out  1  one-cycle pulse: I transaction started
- i_done  out  1  one-cycle pulse: i_data valid
- i_data  out  IDATA_W  fetched instruction; holds until next i_done
- m_req  in  1  micro-instruction fetch request
- m_addr  in  MADDR_W  micro-instruction address; sampled at grant
- m_gnt  out  1  one-cycle pulse: M transaction started
- m_done  out  1  one-cycle pulse: m_data valid
- m_data  out  MDATA_W  fetched micro-instruction
- ser_addr_out  out  1  serial address bit
- ser_frame  out  1  high exactly while address bits are driven
- ser_sel  out  1  0 = instruction memory, 1 = micro memory; valid from grant to done
- ser_data_in  in  1  serial data bit from memory
- busy  out  1  high in every state except IDLE
- perr  out  1  parity error flag, qualified by i_done/m_done

Behaviour:
- Reset: state IDLE, all outputs 0, data/shift registers 0, last_grant = M (so I wins the first tie).
- States and transitions:
  - IDLE -> ADDR when any req is high at the clock edge. Winner: sole requester, else the one not equal to last_grant. Latch address, set ser_sel, update last_grant.
  - ADDR: lasts W cycles (W = IADDR_W or MADDR_W). gnt is high in the first ADDR cycle only; ser_frame=1; ser_addr_out = address bit W-1-k in cycle k.
  - ADDR -> WAIT, lasting TURNAROUND cycles. If TURNAROUND=0, go straight to DATA.
  - DATA: lasts D cycles; ser_data_in is sampled each edge and shifted in MSB-first.
  - DATA -> DONE, one cycle: parallel data register updated, done pulsed, -> IDLE.
- Latency: req sampled at edge e gives done in cycle e+W+TURNAROUND+D+1. Defaults for I: 26 cycles.
- Minimum spacing between consecutive grants is 1 IDLE cycle.
- A req dropped mid-transaction does not abort: the transaction completes and done still pulses.
- A req raised while busy waits; addresses change only when sampled at grant.
- ser_addr_out = 0 whenever ser_frame = 0.
- Counter is $clog2(max(IADDR_W, MADDR_W, IDATA_W, MDATA_W)+1) bits and resets to 0 on every state change.
- Reset asserted mid-transaction: immediate return to reset values; partial data is discarded; no done pulse.

Optional Feature:
- Macro: SERIAL_FETCH_PARITY_EN.
- Defined: DATA is extended by one cycle to capture an even-parity bit after the data LSB. perr = XOR(data bits, parity bit) in the done cycle; data is still delivered.
- Undefined: no extra cycle; perr tied to 0.

Decomposition:
- Shared package (sfa_pkg) holds:
  - the state enum (IDLE, ADDR, WAIT, DATA, DONE)
  - the requester id typedef (REQ_I, REQ_M)
  - the counter-width function and the TURNAROUND bound
- One sub-module, rr_arb2: a 2-way round-robin arbiter with a last_grant register and an enable input.
- Shift and counter logic stays in the top module.

Test Plan:
- Single I request, i_addr=8'hA5, memory returns 16'hBEEF:
  - ser_addr_out = 1,0,1,0,0,1,0,1 with ser_frame high for 8 cycles
  - one WAIT cycle
  - i_done at cycle 26, i_data = 16'hBEEF, ser_sel = 0 throughout
- Both requests held continuously after reset:
  - grant order is I, M, I, M
  - each m transaction (m_addr = 9'h1F3) shows 9 frame cycles and ser_sel = 1
- m_req dropped after m_gnt: transaction completes, m_done pulses once, no second grant.
- sys_reset pulled low during the 4th address bit:
  - outputs 0 asynchronously, busy = 0, no done pulse
  - after release, a tied request grants I first
- TURNAROUND=0 build: first data bit sampled the cycle after the last address bit; I latency is 25 cycles.
- SERIAL_FETCH_PARITY_EN defined, data 16'h0001:
  - parity bit 1 gives perr = 0 with i_done
  - parity bit 0 gives perr = 1, i_data still 16'h0001
  - latency is 27 cycles

Source files
------------

// File: rtl/sfa_pkg.sv
// rtl/sfa_pkg.sv - shared types and helpers for serial_fetch_arbiter
package sfa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        DATA,
        DONE
    } sfa_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_M = 1'b1
    } req_id_t;

    localparam int TURNAROUND_MAX = 3;

    // Bits needed to count 0..max of the four field widths.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/serial_fetch_arbiter_rr_arb2.sv
// rtl/serial_fetch_arbiter_rr_arb2.sv - two-way round-robin arbiter, I wins the first tie after reset
module rr_arb2
    import sfa_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_en,
    input  logic    i_req_i,
    input  logic    i_req_m,
    output logic    o_valid,
    output req_id_t o_winner
);

    req_id_t r_last;

    always_comb begin
        o_winner = REQ_I;
        if (i_req_i && i_req_m) begin
            o_winner = (r_last == REQ_M) ? REQ_I : REQ_M;
        end else if (i_req_m) begin
            o_winner = REQ_M;
        end
    end

    assign o_valid = i_en && (i_req_i || i_req_m);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= REQ_M;
        end else if (o_valid) begin
            r_last <= o_winner;
        end
    end

endmodule

// File: rtl/serial_fetch_arbiter.sv
// rtl/serial_fetch_arbiter.sv - one serial memory port shared by instruction and micro-instruction fetch
// Optional SERIAL_FETCH_PARITY_EN: an even-parity bit follows each fetched word and drives perr.
module serial_fetch_arbiter
    import sfa_pkg::*;
#(
    parameter int IADDR_W    = 8,
    parameter int MADDR_W    = 9,
    parameter int IDATA_W    = 16,
    parameter int MDATA_W    = 16,
    parameter int TURNAROUND = 1
) (
    input  logic               sys_clk,
    input  logic               sys_reset,
    input  logic               i_req,
    input  logic [IADDR_W-1:0] i_addr,
    output logic               i_gnt,
    output logic               i_done,
    output logic [IDATA_W-1:0] i_data,
    input  logic               m_req,
    input  logic [MADDR_W-1:0] m_addr,
    output logic               m_gnt,
    output logic               m_done,
    output logic [MDATA_W-1:0] m_data,
    output logic               ser_addr_out,
    output logic               ser_frame,
    output logic               ser_sel,
    input  logic               ser_data_in,
    output logic               busy,
    output logic               perr
);

    localparam int AW = (IADDR_W > MADDR_W) ? IADDR_W : MADDR_W;
    localparam int DW = (IDATA_W > MDATA_W) ? IDATA_W : MDATA_W;
    localparam int CW = cnt_width(IADDR_W, MADDR_W, IDATA_W, MDATA_W);
    localparam int TA = (TURNAROUND > TURNAROUND_MAX) ? TURNAROUND_MAX : TURNAROUND;
`ifdef SERIAL_FETCH_PARITY_EN
    localparam int PAR_CYC = 1;
`else
    localparam int PAR_CYC = 0;
`endif

    localparam logic [CW-1:0] IA_LAST = CW'(IADDR_W - 1);
    localparam logic [CW-1:0] MA_LAST = CW'(MADDR_W - 1);
    localparam logic [CW-1:0] ID_LAST = CW'(IDATA_W - 1);
    localparam logic [CW-1:0] MD_LAST = CW'(MDATA_W - 1);
    localparam logic [CW-1:0] TA_LAST = (TA == 0) ? '0 : CW'(TA - 1);

    sfa_state_t         r_state;
    sfa_state_t         w_next;
    logic [CW-1:0]      r_cnt;
    req_id_t            r_sel;
    req_id_t            w_winner;
    logic               w_start;
    logic [AW-1:0]      r_addr_sh;
    logic [DW-1:0]      r_data_sh;
    logic [DW-1:0]      w_data_sh_next;
    logic [IDATA_W-1:0] r_i_data;
    logic [MDATA_W-1:0] r_m_data;
    logic [CW-1:0]      w_addr_last;
    logic [CW-1:0]      w_dbit_last;
    logic [CW-1:0]      w_data_last;
    logic               w_data_bit;
    logic               w_done_entry;
    logic               w_first_addr;

    rr_arb2 u_arb (
        .i_clk    (sys_clk),
        .i_rst_n  (sys_reset),
        .i_en     (r_state == IDLE),
        .i_req_i  (i_req),
        .i_req_m  (m_req),
        .o_valid  (w_start),
        .o_winner (w_winner)
    );

    assign w_addr_last  = (r_sel == REQ_M) ? MA_LAST : IA_LAST;
    assign w_dbit_last  = (r_sel == REQ_M) ? MD_LAST : ID_LAST;
    assign w_data_last  = w_dbit_last + CW'(PAR_CYC);
    assign w_data_bit   = (r_state == DATA) && (r_cnt <= w_dbit_last);
    assign w_done_entry = (r_state == DATA) && (r_cnt == w_data_last);
    assign w_first_addr = (r_state == ADDR) && (r_cnt == '0);

    // Word is shifted in at the LSB end so it is right-aligned once all its bits have arrived.
    assign w_data_sh_next = w_data_bit ? {r_data_sh[DW-2:0], ser_data_in} : r_data_sh;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_next = ADDR;
            ADDR: if (r_cnt == w_addr_last) w_next = (TA == 0) ? DATA : WAIT;
            WAIT: if (r_cnt == TA_LAST) w_next = DATA;
            DATA: if (r_cnt == w_data_last) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_sel     <= REQ_I;
            r_addr_sh <= '0;
            r_data_sh <= '0;
            r_i_data  <= '0;
            r_m_data  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
            if (w_start) begin
                r_sel     <= w_winner;
                r_data_sh <= '0;
                // Address is left-aligned so the MSB always leaves from the top bit.
                r_addr_sh <= (w_winner == REQ_M) ? (AW'(m_addr) << (AW - MADDR_W))
                                                 : (AW'(i_addr) << (AW - IADDR_W));
            end else begin
                if (r_state == ADDR) r_addr_sh <= r_addr_sh << 1;
                r_data_sh <= w_data_sh_next;
            end
            if (w_done_entry) begin
                if (r_sel == REQ_M) r_m_data <= w_data_sh_next[MDATA_W-1:0];
                else                r_i_data <= w_data_sh_next[IDATA_W-1:0];
            end
        end
    end

`ifdef SERIAL_FETCH_PARITY_EN
    logic r_par;
    logic r_perr;
    logic w_par_next;
    logic w_perr_next;

    assign w_par_next  = ((r_state == DATA) && !w_data_bit) ? ser_data_in : r_par;
    assign w_perr_next = (r_sel == REQ_M) ? ((^w_data_sh_next[MDATA_W-1:0]) ^ w_par_next)
                                          : ((^w_data_sh_next[IDATA_W-1:0]) ^ w_par_next);

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_par  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            r_par <= w_start ? 1'b0 : w_par_next;
            if (w_done_entry) r_perr <= w_perr_next;
        end
    end

    assign perr = (r_state == DONE) && r_perr;
`else
    assign perr = 1'b0;
`endif

    assign i_gnt        = w_first_addr && (r_sel == REQ_I);
    assign m_gnt        = w_first_addr && (r_sel == REQ_M);
    assign i_done       = (r_state == DONE) && (r_sel == REQ_I);
    assign m_done       = (r_state == DONE) && (r_sel == REQ_M);
    assign i_data       = r_i_data;
    assign m_data       = r_m_data;
    assign ser_frame    = (r_state == ADDR);
    assign ser_addr_out = (r_state == ADDR) && r_addr_sh[AW-1];
    assign ser_sel      = (r_sel == REQ_M);
    assign busy         = (r_state != IDLE);

endmodule
